// File: rtl/apb4_requester_if.sv
// Bundles the command, response and APB bus signals of the APB4 requester.
// The master modport is the requester's view; the slave modport is its environment.
interface apb4_requester_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_strb;
  logic [2:0]            cmd_prot;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [2:0]            pprot;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/apb4_requester.sv
// APB4 requester: turns a valid/ready command stream into setup/access APB4
// transfers with wait states, slave-error capture and a wait-state timeout.
module apb4_requester #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  apb4_requester_if.master  bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e state_q, state_d;

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [2:0]        pprot_q, pprot_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_hit;

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] mask;
    mask = ~ADDR_W'((1 << LSB) - 1);
    return a & mask;
  endfunction

  assign timeout_hit = (TIMEOUT != 0) && !bus.pready && (cnt_q == CNT_LAST);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (bus.pready || timeout_hit) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      IDLE: if (bus.cmd_valid) begin
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwrite_d  = bus.cmd_write;
        paddr_d   = align_addr(bus.cmd_addr);
        // Reads carry no write payload on the bus
        pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
        pstrb_d   = bus.cmd_write ? bus.cmd_strb  : '0;
        pprot_d   = bus.cmd_prot;
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (bus.pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: if (bus.rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pprot       = pprot_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/apb4_requester.md
Name: apb4_requester

Overview:
- Parametrised APB4 requester. Converts a valid/ready command stream into APB4 two-phase (setup/access) transfers.
- Supports PREADY wait states, PSTRB/PPROT, PSLVERR capture and a programmable wait-state timeout.
- Returns one response per command on a valid/ready response channel.
- Sits between a bus-agnostic master (DMA, sequencer, CPU bridge) and an APB peripheral segment.

Parameters:
- ADDR_W, 12: paddr/cmd_addr width.
- DATA_W, 32: data width; legal values 8, 16, 32. Strobe width is DATA_W/8.
- TIMEOUT, 16: max ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- preset  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr seen or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB strobes.
- pprot  out  3  APB protection.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Interface: one clock (pclk); reset (preset) is asynchronous and active-high.
- All outputs are registered except cmd_ready, which equals (state==IDLE).

Reset:
- preset high: state=IDLE immediately.
- psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout = 0.
- paddr, pwdata, pstrb, pprot, rsp_rdata = 0; wait counter = 0.
- Reset mid-transfer drops psel/penable asynchronously and discards the pending command and response; no response is ever issued for it.

States:
- IDLE
  - On cmd_valid && cmd_ready: latch the command; next state SETUP.
  - Same edge: psel=1, penable=0; pwrite, paddr, pwdata, pstrb, pprot driven from the latched command.
- SETUP
  - Unconditional to ACCESS; penable=1; counter cleared.
- ACCESS
  - pready=1: capture prdata if read, else 0; rsp_err=pslverr, rsp_timeout=0; psel=penable=0; go to RESP with rsp_valid=1.
  - pready=0 and TIMEOUT>0 and counter==TIMEOUT-1: rsp_err=1, rsp_timeout=1, rsp_rdata=0; psel=penable=0; go to RESP.
  - Otherwise: counter++; all APB outputs held stable.
- RESP
  - rsp_valid held with stable data until rsp_ready; then rsp_valid=0 and go to IDLE.
  - rsp_ready high before rsp_valid has no effect.

Address and strobe rules:
- paddr = cmd_addr with its low log2(DATA_W/8) bits forced to 0.
- Reads: pstrb=0 regardless of cmd_strb, and pwdata=0.
- Writes: pstrb=cmd_strb, passed through even if all-zero.

Latency:
- With zero wait states, psel rises at edge E (the handshake edge), penable at E+1, and rsp_valid at E+2.
- Each pready-low ACCESS cycle adds one cycle.
- Minimum command-to-command spacing is 4 cycles, with rsp_ready held high.

Timeout and other rules:
- With TIMEOUT=N, an abort follows exactly N ACCESS cycles with pready low. rsp_valid rises at edge E+1+N.
- A late pready arriving after the abort is ignored.
- pslverr is sampled only when pready=1 in ACCESS. For a read with pslverr=1, prdata is still returned.
- Only one transfer is outstanding; no command is accepted while in SETUP, ACCESS or RESP.

Test Plan:
- Zero-wait write: addr 0x104, data 0xDEADBEEF, strb 0xF, pready tied 1 -> psel at E, penable at E+1, rsp_valid at E+2, rsp_err=0, rsp_rdata=0.
- Read with 3 waits: addr 0x20, pready low 3 ACCESS cycles, prdata=0x12345678 -> rsp_valid at E+5, rsp_rdata=0x12345678, pstrb=0 throughout, APB outputs stable during waits.
- Slave error: write, pslverr=1 with pready=1 -> rsp_err=1, rsp_timeout=0; follow-up read accepted after rsp_ready.
- Timeout, TIMEOUT=4: pready never asserted -> psel drops and rsp_valid rises at E+5, rsp_err=1, rsp_timeout=1, rsp_rdata=0; a later pready pulse changes nothing.
- Backpressure plus unaligned address: rsp_ready low 5 cycles, cmd_valid held with addr 0x0107 -> cmd_ready=0 until the response is consumed; next paddr=0x0104.
- Reset mid-ACCESS: assert preset during a wait state -> psel, penable, rsp_valid 0 with no edge required; no response afterward; a new command works normally.
